muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 76 +++++++
 tb/tb_muldiv_seq.sv | 138 +++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: 32-cycle sequential unsigned MULTU/DIVU unit that writes HI/LO and raises stall/done for the issue stage.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_hilo,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0] acc_q, acc_d;
  logic [32:0] mul_sum, div_shift;
  logic [31:0] div_diff;
  logic        div_ge, accept, iter, wr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  always_comb begin
    state_d = flush              ? IDLE :
              state_q == IDLE    ? (start ? (op ? DIV : MUL) : IDLE) :
              state_q == FIN     ? IDLE :
              count_q == 5'd31   ? FIN : state_q;
  end
  // MUL keeps {partial product, remaining multiplier} in acc; DIV keeps {remainder, dividend/quotient}.
  always_comb begin
    accept    = (state_q == IDLE) & start & ~flush;
    iter      = (state_q == MUL) | (state_q == DIV);
    wr        = (state_q == FIN) & ~flush;
    mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, acc_q[0] ? a_q : 32'd0};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_diff  = div_shift[31:0] - b_q;
    a_d       = accept ? a : a_q;
    b_d       = accept ? b : b_q;
    count_d   = accept ? 5'd0 : iter ? count_q + 5'd1 : count_q;
    acc_d     = accept             ? {32'd0, op ? a : b} :
                state_q == MUL     ? {mul_sum, acc_q[31:1]} :
                state_q == DIV     ? {div_ge ? div_diff : div_shift[31:0], acc_q[30:0], div_ge} :
                acc_q;
    hi_d      = wr ? acc_q[63:32] : hi_q;
    lo_d      = wr ? acc_q[31:0] : lo_q;
  end
  always_comb begin
    busy  = state_q != IDLE;
    done  = state_q == FIN;
    stall = busy & (start | rd_hilo);
    hi    = hi_q;
    lo    = lo_q;
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed bench for muldiv_seq with a result scoreboard and immediate-assertion checks.
module tb_muldiv_seq;
  logic        clk = 0, rst_n = 1, start = 0, op = 0, rd_hilo = 0, flush = 0;
  logic [31:0] a = 0, b = 0;
  logic        busy, stall, done;
  logic [31:0] hi, lo;
  int          checks = 0, errors = 0;
  logic [63:0] sb[$];

  muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .rd_hilo(rd_hilo), .flush(flush), .busy(busy), .stall(stall),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(logic o, logic [31:0] x, logic [31:0] y);
    if (o) return (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
    return {32'd0, x} * {32'd0, y};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(logic o, logic [31:0] x, logic [31:0] y, logic rdh, logic poke);
    int n, sc;
    logic [63:0] prev, e;
    prev = {hi, lo};
    sb.push_back(model(o, x, y));
    op = o; a = x; b = y; start = 1;
    tick;
    start = 0; rd_hilo = rdh; a = $urandom; b = $urandom;
    chk("busy_after_start", 64'(busy), 64'd1);
    n = 0; sc = 0;
    while (!done && n < 100) begin
      tick;
      n++;
      sc += int'(stall);
      if (poke && n == 5) begin
        chk("stall_on_busy_start", 64'(stall), 64'd1);
        start = 0;
      end
      if (poke && n == 4) begin
        start = 1; op = ~o;
      end
    end
    chk("done_latency", 64'(n), 64'd32);
    chk("hilo_hold", {hi, lo}, prev);
    chk("stall_cycles", 64'(sc), rdh ? 64'd32 : poke ? 64'd1 : 64'd0);
    tick;
    e = sb.pop_front();
    chk("result", {hi, lo}, e);
    chk("idle_after", 64'({busy, done}), 64'd0);
    chk("stall_idle", 64'(stall), 64'd0);
    rd_hilo = 0;
  endtask

  initial begin
    logic [63:0] prev;
    logic        dn;
    int          n;
    #1 rst_n = 0;
    #1;
    chk("reset_ctrl", 64'({busy, stall, done}), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    tick;
    rst_n = 1;
    run_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    chk("mul_max_hi", 64'(hi), 64'hFFFFFFFE);
    run_op(1, 32'd100, 32'd7, 0, 0);
    chk("div_100_7", {hi, lo}, {32'd2, 32'd14});
    run_op(1, 32'h12345678, 32'd0, 0, 0);
    chk("div_by_zero", {hi, lo}, {32'h12345678, 32'hFFFFFFFF});
    run_op(0, 32'd3, 32'd5, 1, 0);
    chk("mul_3_5", {hi, lo}, 64'd15);
    run_op(0, 32'd6, 32'd7, 0, 1);
    run_op(1, 32'hDEADBEEF, 32'h00012345, 0, 0);
    run_op(0, 32'h89ABCDEF, 32'h76543210, 0, 0);
    run_op(1, 32'd5, 32'hFFFFFFF0, 0, 0);
    prev = {hi, lo};
    op = 1; a = 32'd1000; b = 32'd3; start = 1;
    tick;
    start = 0;
    repeat (9) tick;
    flush = 1;
    tick;
    flush = 0;
    chk("flush_idle", 64'(busy), 64'd0);
    chk("flush_hilo", {hi, lo}, prev);
    dn = 0;
    repeat (40) begin tick; dn |= done; end
    chk("flush_no_done", 64'(dn), 64'd0);
    op = 0; a = 32'd5; b = 32'd5; start = 1; flush = 1;
    tick;
    start = 0; flush = 0;
    chk("flush_start_idle", 64'(busy), 64'd0);
    op = 0; a = 32'd9; b = 32'd9; start = 1;
    tick;
    start = 0;
    n = 0;
    while (!done && n < 100) begin tick; n++; end
    chk("fin_done", 64'(done), 64'd1);
    flush = 1;
    tick;
    flush = 0;
    chk("fin_flush_hilo", {hi, lo}, prev);
    chk("fin_flush_idle", 64'(busy), 64'd0);
    op = 0; a = 32'h1234; b = 32'h5678; start = 1;
    tick;
    start = 0;
    repeat (19) tick;
    rst_n = 0;
    #1;
    chk("async_reset_ctrl", 64'({busy, stall, done}), 64'd0);
    chk("async_reset_hilo", {hi, lo}, 64'd0);
    tick;
    rst_n = 1;
    dn = 0;
    repeat (40) begin tick; dn |= done; end
    chk("reset_no_done", 64'(dn), 64'd0);
    run_op(0, 32'd2, 32'd2, 0, 0);
    chk("mul_2_2", {hi, lo}, 64'd4);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
